parity_frame_tx: RTL and testbench

Transmit-side companion to the parity checker in user_proj_example. It accepts 8-bit words over a valid/ready handshake, computes the parity bit (even or odd, with an optional forced error), and drives two outputs:
- a 9-bit parallel word {parity, data} in the same bit order the checker samples;
- a serial UART-style frame (start, 8 data bits LSB first, parity, stop) paced by a baud divider.

It lives inside user_proj_example next to the checker. Its outputs can loop back to the checker's inputs for self-test.

---
 rtl/parity_tx_pkg.sv | 23 ++
 rtl/baud_tick_gen.sv | 29 ++
 rtl/parity_frame_tx.sv | 124 ++++++++++++
 tb/tb_parity_frame_tx.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/parity_tx_pkg.sv
// Shared types and helpers for the parity frame transmitter.
// Frame: start, 8 data bits LSB first, parity, stop.
package parity_tx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_e;

   localparam int FRAME_BITS = 11;

   function automatic logic calc_parity(
      input logic [7:0] data,
      input logic       odd,
      input logic       inj
   );
      return (^data) ^ odd ^ inj;
   endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Baud divider: one-cycle tick every CLKS_PER_BIT cycles.
// i_clr holds the count at zero so the next bit starts aligned.
module baud_tick_gen #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clr,
   output logic o_tick
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] r_cnt;
   logic          w_wrap;

   assign w_wrap = (r_cnt == LAST);
   assign o_tick = w_wrap & ~i_clr;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n || i_clr || w_wrap) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/parity_frame_tx.sv
// Parity word generator and serial frame transmitter.
// Outputs loop back to the parity checker for self-test.
module parity_frame_tx
   import parity_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int CNT_W        = 16
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_ni,
   input  logic [7:0]       tx_data_i,
   input  logic             tx_valid_i,
   output logic             tx_ready_o,
   input  logic             par_odd_i,
   input  logic             inject_err_i,
   output logic [8:0]       par_word_o,
   output logic             par_word_vld_o,
   output logic             ser_o,
   output logic             busy_o,
   output logic [CNT_W-1:0] frames_sent_o
);

   localparam int DATA_BITS = FRAME_BITS - 3;

   tx_state_e        r_state;
   tx_state_e        w_state_nxt;
   logic [7:0]       r_shift;
   logic [2:0]       r_bit_cnt;
   logic             r_par;
   logic [8:0]       r_word;
   logic             r_vld;
   logic [CNT_W-1:0] r_frames;

   logic w_tick;
   logic w_accept;
   logic w_par;
   logic w_baud_clr;
   logic w_last_bit;
   logic w_shift;
   logic w_frame_done;
   logic w_ser;

   assign w_accept     = tx_valid_i & (r_state == IDLE);
   assign w_par        = calc_parity(tx_data_i, par_odd_i, inject_err_i);
   assign w_baud_clr   = (r_state == IDLE);
   assign w_last_bit   = (r_bit_cnt == 3'(DATA_BITS - 1));
   assign w_shift      = (r_state == DATA) & w_tick;
   assign w_frame_done = (r_state == STOP) & w_tick;

   baud_tick_gen #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .i_clk  (wb_clk_i),
      .i_rst_n(wb_rst_ni),
      .i_clr  (w_baud_clr),
      .o_tick (w_tick)
   );

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ser       = 1'b1;
      unique case (r_state)
         IDLE: begin
            if (w_accept) w_state_nxt = START;
         end
         START: begin
            w_ser = 1'b0;
            if (w_tick) w_state_nxt = DATA;
         end
         DATA: begin
            w_ser = r_shift[0];
            if (w_tick && w_last_bit) w_state_nxt = PARITY;
         end
         PARITY: begin
            w_ser = r_par;
            if (w_tick) w_state_nxt = STOP;
         end
         STOP: begin
            if (w_tick) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Bit counter wraps 7 -> 0 naturally on the last DATA shift
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) begin
         r_shift   <= '0;
         r_bit_cnt <= '0;
         r_par     <= 1'b0;
         r_word    <= '0;
         r_vld     <= 1'b0;
         r_frames  <= '0;
      end else begin
         r_vld <= w_accept;
         if (w_accept) begin
            r_shift   <= tx_data_i;
            r_par     <= w_par;
            r_word    <= {w_par, tx_data_i};
            r_bit_cnt <= '0;
         end else if (w_shift) begin
            r_shift   <= {1'b0, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
         end
         if (w_frame_done) r_frames <= r_frames + CNT_W'(1);
      end
   end

   assign tx_ready_o     = (r_state == IDLE);
   assign busy_o         = (r_state != IDLE);
   assign ser_o          = w_ser;
   assign par_word_o     = r_word;
   assign par_word_vld_o = r_vld;
   assign frames_sent_o  = r_frames;

endmodule

// File: tb/tb_parity_frame_tx.sv
// Scoreboard bench for parity_frame_tx: random and directed words
// checked against a reference frame model.
module tb_parity_frame_tx;

   localparam int N  = 16;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [7:0]    tx_data = '0;
   logic          tx_valid = 1'b0;
   logic          par_odd = 1'b0;
   logic          inj = 1'b0;
   logic          tx_ready_o;
   logic [8:0]    par_word_o;
   logic          par_word_vld_o;
   logic          ser_o;
   logic          busy_o;
   logic [CW-1:0] frames_sent_o;

   parity_frame_tx #(
      .CLKS_PER_BIT(N),
      .CNT_W       (CW)
   ) dut (
      .wb_clk_i      (clk),
      .wb_rst_ni     (rst_n),
      .tx_data_i     (tx_data),
      .tx_valid_i    (tx_valid),
      .tx_ready_o    (tx_ready_o),
      .par_odd_i     (par_odd),
      .inject_err_i  (inj),
      .par_word_o    (par_word_o),
      .par_word_vld_o(par_word_vld_o),
      .ser_o         (ser_o),
      .busy_o        (busy_o),
      .frames_sent_o (frames_sent_o)
   );

   always #5 clk = ~clk;

   int            checks = 0;
   int            failures = 0;
   logic [8:0]    q_word[$];
   logic [10:0]   q_frame[$];
   int            gaps[$];
   int            ph = -1;
   logic [10:0]   cur = '0;
   logic [8:0]    last_word = '0;
   logic [CW-1:0] exp_frames = '0;
   logic          prev_vld = 1'b0;
   longint        cyc = 0;
   longint        last_end = -1000;

   task automatic check(input string nm,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic logic ref_par(input logic [7:0] d,
                                    input logic o,
                                    input logic e);
      int ones;
      ones = $countones(d) + int'(o) + int'(e);
      return (ones % 2) == 1;
   endfunction

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         ph = -1;
         exp_frames = '0;
         prev_vld = 1'b0;
      end else begin
         if (par_word_vld_o) begin
            check("vld_one_cycle", 32'(prev_vld), 0);
            check("word_expected", 32'(q_word.size() != 0), 1);
            if (q_word.size() != 0) begin
               last_word = q_word.pop_front();
               check("par_word", 32'(par_word_o), 32'(last_word));
            end
         end
         prev_vld = par_word_vld_o;
         if (ph < 0 && !ser_o) begin
            check("frame_expected", 32'(q_frame.size() != 0), 1);
            if (q_frame.size() != 0) begin
               cur = q_frame.pop_front();
               ph = 0;
               gaps.push_back(int'(cyc - last_end));
            end
         end
         if (ph >= 0) begin
            if (ph % N == N / 2)
               check($sformatf("ser_bit%0d", ph / N),
                     32'(ser_o), 32'(cur[ph/N]));
            if (ph == 0) check("busy_in_frame", 32'(busy_o), 1);
            if (ph == 11 * N - 1)
               check("ready_low_at_end", 32'(tx_ready_o), 0);
            if (ph == 11 * N) begin
               exp_frames++;
               check("ready_after_frame", 32'(tx_ready_o), 1);
               check("busy_after_frame", 32'(busy_o), 0);
               check("ser_idle", 32'(ser_o), 1);
               check("frames_sent", 32'(frames_sent_o),
                     32'(exp_frames));
               check("word_held", 32'(par_word_o), 32'(last_word));
               last_end = cyc;
               ph = -1;
            end else begin
               ph++;
            end
         end
      end
   end

   task automatic send(input logic [7:0] d, input logic o,
                       input logic e, input bit keep);
      int t = 0;
      logic p;
      @(negedge clk);
      while (!tx_ready_o && t < 20 * N) begin
         @(negedge clk);
         t++;
      end
      check("ready_wait", 32'(tx_ready_o), 1);
      p = ref_par(d, o, e);
      tx_data = d;
      par_odd = o;
      inj = e;
      tx_valid = 1'b1;
      q_word.push_back({p, d});
      q_frame.push_back({1'b1, p, d, 1'b0});
      @(posedge clk);
      #1;
      if (!keep) tx_valid = 1'b0;
      tx_data = 8'($urandom);
      par_odd = 1'($urandom);
      inj = 1'($urandom);
   endtask

   task automatic wait_idle();
      int t = 0;
      while ((ph >= 0 || q_frame.size() != 0 || !tx_ready_o)
             && t < 40 * N) begin
         @(negedge clk);
         t++;
      end
      check("idle_wait", 32'(t < 40 * N), 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [CW-1:0] f0;
      bit keep;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", 32'(tx_ready_o), 1);
      check("rst_ser", 32'(ser_o), 1);
      check("rst_busy", 32'(busy_o), 0);
      check("rst_word", 32'(par_word_o), 0);
      check("rst_vld", 32'(par_word_vld_o), 0);
      check("rst_frames", 32'(frames_sent_o), 0);
      rst_n = 1'b1;

      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         check("idle_ser", 32'(ser_o), 1);
         check("idle_ready", 32'(tx_ready_o), 1);
         check("idle_frames", 32'(frames_sent_o), 0);
      end

      send(8'hA5, 1'b0, 1'b0, 1'b0);
      check("a5_even_word", 32'(par_word_o), 32'h0A5);
      check("a5_vld", 32'(par_word_vld_o), 1);
      wait_idle();
      check("a5_frames", 32'(frames_sent_o), 1);

      send(8'hA5, 1'b1, 1'b0, 1'b0);
      check("a5_odd_word", 32'(par_word_o), 32'h1A5);
      wait_idle();
      send(8'h07, 1'b0, 1'b0, 1'b0);
      check("07_even_word", 32'(par_word_o), 32'h107);
      wait_idle();
      send(8'h07, 1'b0, 1'b1, 1'b0);
      check("07_inj_word", 32'(par_word_o), 32'h007);
      wait_idle();

      gaps.delete();
      f0 = frames_sent_o;
      send(8'h00, 1'b0, 1'b0, 1'b1);
      send(8'hFF, 1'b0, 1'b0, 1'b1);
      send(8'h3C, 1'b0, 1'b0, 1'b0);
      wait_idle();
      check("b2b_gap_count", 32'(gaps.size()), 3);
      if (gaps.size() == 3) begin
         check("b2b_gap1", 32'(gaps[1]), 1);
         check("b2b_gap2", 32'(gaps[2]), 1);
      end
      check("b2b_frames", 32'(frames_sent_o), 32'(f0 + CW'(3)));

      send(8'h5A, 1'b0, 1'b0, 1'b0);
      repeat (5 * N + N / 2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("abort_ser", 32'(ser_o), 1);
      check("abort_ready", 32'(tx_ready_o), 1);
      check("abort_busy", 32'(busy_o), 0);
      check("abort_frames", 32'(frames_sent_o), 0);
      rst_n = 1'b1;
      send(8'hC3, 1'b1, 1'b0, 1'b0);
      check("post_abort_word", 32'(par_word_o), 32'h1C3);
      wait_idle();
      check("post_abort_frames", 32'(frames_sent_o), 1);

      for (int i = 0; i < 25; i++) begin
         keep = 1'($urandom_range(0, 1));
         send(8'($urandom), 1'($urandom), 1'($urandom), keep);
         if (!keep) repeat ($urandom_range(0, 20)) @(posedge clk);
      end
      send(8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      wait_idle();
      repeat (4) @(negedge clk);
      check("words_drained", 32'(q_word.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
